// File: rtl/vram_ctrl.sv
// vram_ctrl: shares the VRAM write port between a 2-entry CPU store FIFO and a screen-clear engine.
// Optional range check on CPU word index is built when VRAM_CTRL_BOUNDS_EN is defined.
package arm_const;
  localparam int VGA_SCREEN_SIZE = 2400;
endpackage

module vram_ctrl #(
  parameter int WORDS = arm_const::VGA_SCREEN_SIZE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_we,
  input  logic [13:0] cpu_a,
  input  logic [31:0] cpu_wd,
  output logic        cpu_ready,
  input  logic        clr_start,
  input  logic [31:0] clr_word,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        vram_we,
  output logic [13:0] vram_a,
  output logic [31:0] vram_wd,
  output logic        oob_err
);
  localparam int FIFO_DEPTH = 2;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t      state;
  logic [11:0] fa [FIFO_DEPTH];
  logic [31:0] fd [FIFO_DEPTH];
  logic        wp, rp;
  logic [1:0]  count;
  logic [11:0] idx;
  logic [31:0] fill;
  logic        last_cpu;
  logic        push, cpu_req, gnt_cpu, gnt_clr, pop_oob;
  logic        unused_low_addr;
  assign unused_low_addr = ^cpu_a[1:0];
  // ready comes from the registered count only, so a full FIFO never takes a write in a pop cycle
  assign cpu_ready = count < 2'(FIFO_DEPTH);
  assign push      = cpu_we && cpu_ready;
  assign cpu_req   = count != 2'd0;
  assign clr_busy  = state == CLEAR;
  assign gnt_cpu   = cpu_req && (state != CLEAR || !last_cpu);
  assign gnt_clr   = state == CLEAR && (!cpu_req || last_cpu);
`ifdef VRAM_CTRL_BOUNDS_EN
  assign pop_oob = {1'b0, fa[rp]} >= 13'(WORDS);
  // sticky flag for CPU stores that fall outside the screen
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) oob_err <= 1'b0;
    else if (gnt_cpu && pop_oob) oob_err <= 1'b1;
`else
  assign pop_oob = 1'b0;
  assign oob_err = 1'b0;
`endif
  // FIFO storage; contents are don't-care while the entry is not counted
  always_ff @(posedge clk)
    if (push) begin
      fa[wp] <= cpu_a[13:2];
      fd[wp] <= cpu_wd;
    end
  // FIFO pointers and occupancy; a CPU grant is the pop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (gnt_cpu) rp <= ~rp;
      count <= count + 2'(push) - 2'(gnt_cpu);
    end
  // clear engine: start only from IDLE, advance one word per clear grant
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      idx   <= 12'd0;
      fill  <= 32'd0;
    end else if (state == IDLE) begin
      if (clr_start) begin
        state <= CLEAR;
        idx   <= 12'd0;
        fill  <= clr_word;
      end
    end else if (gnt_clr) begin
      idx <= idx + 12'd1;
      if (idx == 12'(WORDS - 1)) state <= IDLE;
    end
  // registered write port; address/data hold when nothing is written
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vram_we  <= 1'b0;
      vram_a   <= 14'd0;
      vram_wd  <= 32'd0;
      clr_done <= 1'b0;
      last_cpu <= 1'b0;
    end else begin
      vram_we  <= gnt_clr || (gnt_cpu && !pop_oob);
      clr_done <= gnt_clr && idx == 12'(WORDS - 1);
      if (gnt_clr) begin
        vram_a  <= {idx, 2'b00};
        vram_wd <= fill;
      end else if (gnt_cpu && !pop_oob) begin
        vram_a  <= {fa[rp], 2'b00};
        vram_wd <= fd[rp];
      end
      if (gnt_cpu || gnt_clr) last_cpu <= gnt_cpu;
    end
endmodule
